// File: rtl/inst_loader.sv
// inst_loader: serial boot loader feeding the core's instruction memory.
// Deserialises an LSB-first bit stream (wInst, qualified by sclk rising
// edges while IWEN is high) into INST_W-bit words, writes them to
// consecutive instruction-memory addresses, then releases the core.
// Optional build macro INST_LOADER_CHKSUM_EN adds a running XOR checksum
// output (chksum) over every written word.
module inst_loader #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IWEN,
  input  logic              sclk,
  input  logic              wInst,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              frag_err,
  output logic              wrap
`ifdef INST_LOADER_CHKSUM_EN
  ,
  output logic [INST_W-1:0] chksum
`endif
);

  localparam int CNT_W = $clog2(INST_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(INST_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic              sclk_s1, sclk_s2, sclk_s3;
  logic              iwen_s1, iwen_s2;
  logic              winst_s1, winst_s2;
  logic [INST_W-1:0] sh;
  logic [INST_W-1:0] sh_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              bit_event;

  // A bit is taken on a synchronised sclk rising edge inside the load window
  assign bit_event = sclk_s2 & ~sclk_s3 & iwen_s2;
  assign sh_next   = {winst_s2, sh[INST_W-1:1]};

  // Bring the asynchronous boot-interface pins into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      iwen_s1  <= 1'b0;
      iwen_s2  <= 1'b0;
      winst_s1 <= 1'b0;
      winst_s2 <= 1'b0;
    end else begin
      sclk_s1  <= sclk;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      iwen_s1  <= IWEN;
      iwen_s2  <= iwen_s1;
      winst_s1 <= wInst;
      winst_s2 <= winst_s1;
    end
  end

  // Load sequencer: collect bits, write whole words, then release the core once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sh         <= '0;
      bit_cnt    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      cpu_start  <= 1'b0;
      frag_err   <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_hold <= 1'b1;
          // An edge can be decoded in the same cycle the window opens
          if (bit_event) begin
            sh      <= sh_next;
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (iwen_s2) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_event) begin
            sh <= sh_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              imem_we    <= 1'b1;
              imem_wdata <= sh_next;
              state      <= WRITE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (!iwen_s2) begin
            if (bit_cnt != '0) begin
              frag_err <= 1'b1;
            end
            bit_cnt   <= '0;
            cpu_hold  <= 1'b0;
            cpu_start <= 1'b1;
            state     <= DONE;
          end
        end
        WRITE: begin
          imem_we   <= 1'b0;
          imem_addr <= imem_addr + 1'b1;
          if (imem_addr == '1) begin
            wrap <= 1'b1;
          end
          state <= SHIFT;
        end
        DONE: begin
          cpu_hold  <= 1'b0;
          cpu_start <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef INST_LOADER_CHKSUM_EN
  // Fold each word into the checksum the cycle after its write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum <= '0;
    end else if (state == WRITE) begin
      chksum <= chksum ^ imem_wdata;
    end
  end
`else
  // Checksum disabled: no port and no logic
`endif

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader.
// A default instance (ADDR_W=8) and a small one (ADDR_W=2) share stimulus,
// so the small one exercises address wrap during the multi-word load.
module tb_inst_loader;

  logic        clk;
  logic        rst;
  logic        IWEN;
  logic        sclk;
  logic        wInst;

  logic        imem_we, cpu_hold, cpu_start, frag_err, wrap;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        sm_we, sm_hold, sm_start, sm_frag, sm_wrap;
  logic [1:0]  sm_addr;
  logic [31:0] sm_wdata;
`ifdef INST_LOADER_CHKSUM_EN
  logic [31:0] chksum;
  logic [31:0] sm_chksum;
`endif

  int n_cmp;
  int n_fail;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] sm_wr_addr[$];
  int          start_cnt;

  logic [31:0] words[9];

  inst_loader #(.ADDR_W(8), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .IWEN(IWEN), .sclk(sclk), .wInst(wInst),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .frag_err(frag_err),
    .wrap(wrap)
`ifdef INST_LOADER_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  inst_loader #(.ADDR_W(2), .INST_W(32)) dut_small (
    .clk(clk), .rst(rst), .IWEN(IWEN), .sclk(sclk), .wInst(wInst),
    .imem_we(sm_we), .imem_addr(sm_addr), .imem_wdata(sm_wdata),
    .cpu_hold(sm_hold), .cpu_start(sm_start), .frag_err(sm_frag),
    .wrap(sm_wrap)
`ifdef INST_LOADER_CHKSUM_EN
    , .chksum(sm_chksum)
`endif
  );

  // 10 ns system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe and start pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back({24'd0, imem_addr});
      wr_data.push_back(imem_wdata);
    end
    if (sm_we) begin
      sm_wr_addr.push_back({30'd0, sm_addr});
    end
    if (cpu_start) begin
      start_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the low bits of a word LSB first, sclk half-period of 2 clk cycles
  task automatic applyStimulus(input logic [31:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      wInst = word[i];
      sclk  = 1'b0;
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxxxxxx;
  endfunction

  initial begin
    int base_w;
    int base_sm;
    int base_s;
    logic [31:0] xsum;

    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    IWEN = 1'b0;
    sclk = 1'b0;
    wInst = 1'b0;
    words[0] = 32'h1304500a;
    words[1] = 32'h00a00093;
    words[2] = 32'h00100113;
    words[3] = 32'h002081b3;
    words[4] = 32'h40208233;
    words[5] = 32'h0020f2b3;
    words[6] = 32'h0020e333;
    words[7] = 32'h0020c3b3;
    words[8] = 32'h33068600;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_we",    {31'd0, imem_we},   32'd0);
    checkOutput("rst_addr",  {24'd0, imem_addr}, 32'd0);
    checkOutput("rst_wdata", imem_wdata,         32'd0);
    checkOutput("rst_hold",  {31'd0, cpu_hold},  32'd1);
    checkOutput("rst_start", {31'd0, cpu_start}, 32'd0);
    checkOutput("rst_frag",  {31'd0, frag_err},  32'd0);
    checkOutput("rst_wrap",  {31'd0, wrap},      32'd0);
`ifdef INST_LOADER_CHKSUM_EN
    checkOutput("rst_chksum", chksum, 32'd0);
`endif

    // Single word load
    base_w = wr_addr.size();
    base_s = start_cnt;
    IWEN = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(32'h1304500a, 32);
    repeat (8) @(negedge clk);
    checkOutput("one_hold_during", {31'd0, cpu_hold}, 32'd1);
    IWEN = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("one_nwrites", wr_addr.size() - base_w, 32'd1);
    checkOutput("one_addr",    qget(wr_addr, base_w), 32'd0);
    checkOutput("one_data",    qget(wr_data, base_w), 32'h1304500a);
    checkOutput("one_start",   start_cnt - base_s, 32'd1);
    checkOutput("one_hold",    {31'd0, cpu_hold}, 32'd0);
    checkOutput("one_frag",    {31'd0, frag_err}, 32'd0);
    checkOutput("one_ptr",     {24'd0, imem_addr}, 32'd1);

    // Nine words back to back
    doReset();
    checkOutput("nine_rst_addr", {24'd0, imem_addr}, 32'd0);
    base_w  = wr_addr.size();
    base_sm = sm_wr_addr.size();
    IWEN = 1'b1;
    repeat (4) @(negedge clk);
    xsum = 32'd0;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(words[k], 32);
      xsum = xsum ^ words[k];
      repeat (4) @(negedge clk);
    end
    IWEN = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("nine_nwrites", wr_addr.size() - base_w, 32'd9);
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("nine_addr%0d", k), qget(wr_addr, base_w + k), k);
      checkOutput($sformatf("nine_data%0d", k), qget(wr_data, base_w + k), words[k]);
      checkOutput($sformatf("small_addr%0d", k), qget(sm_wr_addr, base_sm + k), k % 4);
    end
    checkOutput("nine_wrap_big",   {31'd0, wrap},    32'd0);
    checkOutput("nine_wrap_small", {31'd0, sm_wrap}, 32'd1);
    checkOutput("nine_frag",       {31'd0, frag_err}, 32'd0);
`ifdef INST_LOADER_CHKSUM_EN
    checkOutput("nine_chksum", chksum, xsum);
`endif

    // Partial word then window closes
    doReset();
    base_w = wr_addr.size();
    base_s = start_cnt;
    IWEN = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(32'h0001ffff, 17);
    IWEN = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("frag_nwrites", wr_addr.size() - base_w, 32'd0);
    checkOutput("frag_err",     {31'd0, frag_err}, 32'd1);
    checkOutput("frag_start",   start_cnt - base_s, 32'd1);
    checkOutput("frag_hold",    {31'd0, cpu_hold}, 32'd0);

    // Load window reopened after DONE is ignored
    base_w = wr_addr.size();
    base_s = start_cnt;
    IWEN = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(32'hdeadbeef, 32);
    repeat (8) @(negedge clk);
    checkOutput("late_nwrites", wr_addr.size() - base_w, 32'd0);
    checkOutput("late_hold",    {31'd0, cpu_hold}, 32'd0);
    checkOutput("late_start",   start_cnt - base_s, 32'd0);
    IWEN = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of the second word
    doReset();
    IWEN = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(words[1], 32);
    repeat (4) @(negedge clk);
    applyStimulus(words[2], 10);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_we",    {31'd0, imem_we},   32'd0);
    checkOutput("mid_addr",  {24'd0, imem_addr}, 32'd0);
    checkOutput("mid_wdata", imem_wdata,         32'd0);
    checkOutput("mid_hold",  {31'd0, cpu_hold},  32'd1);
    checkOutput("mid_start", {31'd0, cpu_start}, 32'd0);
    checkOutput("mid_frag",  {31'd0, frag_err},  32'd0);
    checkOutput("mid_wrap",  {31'd0, wrap},      32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    base_w = wr_addr.size();
    applyStimulus(words[8], 32);
    repeat (6) @(negedge clk);
    IWEN = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("reload_nwrites", wr_addr.size() - base_w, 32'd1);
    checkOutput("reload_addr",    qget(wr_addr, base_w), 32'd0);
    checkOutput("reload_data",    qget(wr_data, base_w), words[8]);
    checkOutput("reload_frag",    {31'd0, frag_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
